key_tone_gen: RTL
=================

Name: key_tone_gen

Overview:
- Downstream of the switch-to-LED stage. Consumes the same seven key switches (switch17..switch11) and turns them into audio.
- Debounces each key and selects one note by priority. A divider generates a square-wave tone for that note.
- Emits 16-bit signed samples at a fixed rate over a valid/ready handshake to the audio codec interface.

Parameters:
- DEB_CYCLES, 500000: consecutive stable clocks needed to accept a key change (10 ms at 50 MHz); minimum 2.
- SAMPLE_DIV, 1042: clocks per output sample (about 48 kHz at 50 MHz); minimum 2.
- AMPLITUDE, 8000: square-wave magnitude; the sample is +AMPLITUDE or -AMPLITUDE.
- TONE_SHIFT, 0: right shift applied to every half-period constant; used only to shorten simulation.

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-high reset
- key_in  in  7  raw switches; [6]=switch17=C4, [5]=D4, [4]=E4, [3]=F4, [2]=G4, [1]=A4, [0]=switch11=B4
- sample_ready  in  1  codec accepts the sample
- sample_valid  out  1  sample_data holds a valid sample
- sample_data  out  16  signed two's-complement sample
- note_active  out  1  at least one debounced key is down
- note_idx  out  3  index of the selected key, 6..0
- overrun  out  1  sticky; a sample tick was dropped

Behaviour:
- Reset: every output is 0 and all internal counters are 0. Debounced key state is 0 and phase is 0.
- Reset is asynchronous and active-high. Asserting it mid-tone or mid-handshake returns the block to the reset state immediately; in-flight data is not retained.
- Sync: each key_in bit passes through a 2-flop synchroniser.
- Debounce, per key:
  - A counter increments while the synced value differs from the stable value and clears when they agree.
  - When the counter reaches DEB_CYCLES-1, the stable value takes the synced value and the counter clears.
- Select:
  - note_active = OR of the stable bits.
  - note_idx = highest set stable bit. Bit 6 has priority.
  - Both are registered, so they update 1 clock after the stable value changes.
  - With no key down, note_idx holds its last value.
- Half periods: HP = round(50e6 / (2 * f)) >> TONE_SHIFT. The 17-bit constants are:
  - C4 95556
  - D4 85131
  - E4 75843
  - F4 71586
  - G4 63776
  - A4 56818
  - B4 50619
- Tone divider:
  - half_cnt counts down. At 0 it reloads HP-1 and phase toggles.
  - When note_idx or note_active changes (in the same clock as their registered update), half_cnt loads HP-1 for the new note and phase clears to 0.
  - While note_active=0, half_cnt and phase stay 0.
- Sample tick:
  - tick_cnt runs 0..SAMPLE_DIV-1 and wraps freely. A tick occurs at wrap.
  - Sample value = note_active ? (phase ? +AMPLITUDE : -AMPLITUDE) : 0.
- Handshake:
  - A transfer happens when sample_valid && sample_ready.
  - While valid && !ready, sample_data and sample_valid hold stable.
  - Tick with sample_valid=0: load sample_data, set sample_valid the next cycle.
  - Tick in the same cycle as a transfer: load the new sample; sample_valid stays 1.
  - Tick while valid && !ready: the new sample is dropped, the old sample is held, and overrun sets. overrun clears only on reset.
  - Transfer with no tick: sample_valid clears.
- Simultaneous key changes resolve by priority only; there is no ordering memory.

Optional Feature:
- Macro: KEY_TONE_OCTAVE_EN.
- Defined:
  - Adds port octave_up (in, 1).
  - octave_up passes through its own 2-flop synchroniser.
  - When octave_up is high, the effective HP is HP >> 1, one octave up.
  - A change of the synced octave_up is treated as a note change: half_cnt reloads and phase clears.
- Undefined: the port is absent and HP is used unmodified.

Test Plan:
All scenarios use DEB_CYCLES=4, SAMPLE_DIV=8, TONE_SHIFT=10, AMPLITUDE=8000.
1. Reset: assert reset mid-tone with sample_valid=1 -> all outputs 0 immediately; after release, sample_valid first rises about 9 clocks later with sample_data=0.
2. Debounce: key_in[1] glitches high for 3 clocks -> note_active stays 0. Hold it high for ≥ 2+4+1 clocks -> note_active=1, note_idx=1.
3. Tone: hold A4 with sample_ready=1 -> phase toggles every 55 clocks (56818>>10=55). Samples read -8000 for the first 55 clocks, then +8000.
4. Priority: A4 and C4 held together -> note_idx=6 and the half period is 93 clocks. Release C4 -> note_idx=1, half_cnt reloads, and the first sample after the change is -8000.
5. Backpressure: sample_ready=0 for 20 clocks -> sample_data is held, overrun=1 after the second tick. Raise ready -> exactly one transfer of the held value; overrun stays 1.
6. Tick plus transfer in the same cycle -> sample_valid stays 1, sample_data updates, and no overrun.

Source files
------------

// File: rtl/key_tone_gen_if.sv
// Key-tone generator bus: raw key switches in, audio samples out over valid/ready, status flags.
// With KEY_TONE_OCTAVE_EN defined the bus also carries the octave_up input.
interface key_tone_gen_if;
    logic [6:0]         key_in;
    logic               sample_ready;
    logic               sample_valid;
    logic signed [15:0] sample_data;
    logic               note_active;
    logic [2:0]         note_idx;
    logic               overrun;
`ifdef KEY_TONE_OCTAVE_EN
    logic               octave_up;

    modport master (
        input  key_in, sample_ready, octave_up,
        output sample_valid, sample_data, note_active, note_idx, overrun
    );
    modport slave (
        output key_in, sample_ready, octave_up,
        input  sample_valid, sample_data, note_active, note_idx, overrun
    );
`else
    modport master (
        input  key_in, sample_ready,
        output sample_valid, sample_data, note_active, note_idx, overrun
    );
    modport slave (
        output key_in, sample_ready,
        input  sample_valid, sample_data, note_active, note_idx, overrun
    );
`endif
endinterface

// File: rtl/key_tone_gen.sv
// Seven debounced keys select a note by priority; a square-wave tone is streamed as 16-bit samples.
// Optional KEY_TONE_OCTAVE_EN adds a synchronised octave_up input that halves every half period.
module key_tone_gen #(
    parameter int unsigned DEB_CYCLES = 500000,
    parameter int unsigned SAMPLE_DIV = 1042,
    parameter int unsigned AMPLITUDE  = 8000,
    parameter int unsigned TONE_SHIFT = 0
) (
    input logic             clk,
    input logic             reset,
    key_tone_gen_if.master  io_bus
);
    localparam int unsigned DebW  = $clog2(DEB_CYCLES);
    localparam int unsigned TickW = $clog2(SAMPLE_DIV);
    localparam logic [DebW-1:0]  DebLast  = DebW'(DEB_CYCLES - 1);
    localparam logic [TickW-1:0] TickLast = TickW'(SAMPLE_DIV - 1);
    localparam logic signed [15:0] AmpPos = 16'(AMPLITUDE);
    localparam logic signed [15:0] AmpNeg = -AmpPos;

    logic [6:0]         r_key_s1, r_key_s2, r_stable;
    logic [DebW-1:0]    r_deb_cnt [7];
    logic               r_note_active;
    logic [2:0]         r_note_idx;
    logic [16:0]        r_half_cnt;
    logic               r_phase;
    logic [TickW-1:0]   r_tick_cnt;
    logic               r_sample_valid;
    logic signed [15:0] r_sample_data;
    logic               r_overrun;

    logic               w_any, w_oct, w_oct_chg, w_note_chg, w_tick, w_xfer;
    logic [2:0]         w_idx;
    logic [16:0]        w_hp;
    logic signed [15:0] w_sample;

    function automatic logic [16:0] hp_base(input logic [2:0] idx);
        logic [31:0] hp;
        case (idx)
            3'd6:    hp = 32'd95556;
            3'd5:    hp = 32'd85131;
            3'd4:    hp = 32'd75843;
            3'd3:    hp = 32'd71586;
            3'd2:    hp = 32'd63776;
            3'd1:    hp = 32'd56818;
            default: hp = 32'd50619;
        endcase
        return 17'(hp >> TONE_SHIFT);
    endfunction

`ifdef KEY_TONE_OCTAVE_EN
    logic r_oct_s1, r_oct_s2, r_oct_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_oct_s1 <= 1'b0;
            r_oct_s2 <= 1'b0;
            r_oct_q  <= 1'b0;
        end else begin
            r_oct_s1 <= io_bus.octave_up;
            r_oct_s2 <= r_oct_s1;
            r_oct_q  <= r_oct_s2;
        end
    end

    assign w_oct     = r_oct_s2;
    assign w_oct_chg = r_oct_s2 ^ r_oct_q;
`else
    assign w_oct     = 1'b0;
    assign w_oct_chg = 1'b0;
`endif

    always_comb begin
        // Ascending scan so the highest set key wins.
        w_idx = 3'd0;
        for (int k = 0; k < 7; k++) begin
            if (r_stable[k]) w_idx = 3'(k);
        end
        w_any = |r_stable;
        w_hp  = hp_base(w_idx) >> w_oct;
        if (w_hp == 17'd0) w_hp = 17'd1;
        w_note_chg = (w_any != r_note_active) || (w_idx != r_note_idx) || w_oct_chg;
        w_tick     = (r_tick_cnt == TickLast);
        w_xfer     = r_sample_valid && io_bus.sample_ready;
        if (!r_note_active) w_sample = '0;
        else if (r_phase)   w_sample = AmpPos;
        else                w_sample = AmpNeg;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_key_s1      <= '0;
            r_key_s2      <= '0;
            r_stable      <= '0;
            for (int k = 0; k < 7; k++) r_deb_cnt[k] <= '0;
            r_note_active <= 1'b0;
            r_note_idx    <= 3'd0;
        end else begin
            r_key_s1 <= io_bus.key_in;
            r_key_s2 <= r_key_s1;
            for (int k = 0; k < 7; k++) begin
                if (r_key_s2[k] == r_stable[k]) begin
                    r_deb_cnt[k] <= '0;
                end else if (r_deb_cnt[k] == DebLast) begin
                    r_stable[k]  <= r_key_s2[k];
                    r_deb_cnt[k] <= '0;
                end else begin
                    r_deb_cnt[k] <= r_deb_cnt[k] + DebW'(1);
                end
            end
            r_note_active <= w_any;
            if (w_any) r_note_idx <= w_idx;
        end
    end

    // Reload coincides with the registered note update so a new note always starts at phase 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_half_cnt <= '0;
            r_phase    <= 1'b0;
        end else if (!w_any) begin
            r_half_cnt <= '0;
            r_phase    <= 1'b0;
        end else if (w_note_chg) begin
            r_half_cnt <= w_hp - 17'd1;
            r_phase    <= 1'b0;
        end else if (r_half_cnt == 17'd0) begin
            r_half_cnt <= w_hp - 17'd1;
            r_phase    <= ~r_phase;
        end else begin
            r_half_cnt <= r_half_cnt - 17'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick_cnt     <= '0;
            r_sample_valid <= 1'b0;
            r_sample_data  <= '0;
            r_overrun      <= 1'b0;
        end else begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TickW'(1);
            if (w_tick) begin
                if (!r_sample_valid || w_xfer) begin
                    r_sample_data  <= w_sample;
                    r_sample_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (w_xfer) begin
                r_sample_valid <= 1'b0;
            end
        end
    end

    assign io_bus.sample_valid = r_sample_valid;
    assign io_bus.sample_data  = r_sample_data;
    assign io_bus.note_active  = r_note_active;
    assign io_bus.note_idx     = r_note_idx;
    assign io_bus.overrun      = r_overrun;
endmodule
